// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared constants for the single-clock parametrised FIFO.
//                Bit positions of the 8-bit flag vector
//                {FULL,FMO,FWM,OVERRUN,EMPTY,EPO,EWM,UNDERRUN}, read-mode
//                selectors and a helper that turns an address width into a
//                depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int c_FLAG_UNDERRUN = 0;
  localparam int c_FLAG_EWM      = 1;
  localparam int c_FLAG_EPO      = 2;
  localparam int c_FLAG_EMPTY    = 3;
  localparam int c_FLAG_OVERRUN  = 4;
  localparam int c_FLAG_FWM      = 5;
  localparam int c_FLAG_FMO      = 6;
  localparam int c_FLAG_FULL     = 7;
  localparam int c_FLAG_W        = 8;

  localparam int c_FWFT_OFF = 0;
  localparam int c_FWFT_ON  = 1;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ram
//  Description : Simple dual-port storage for the FIFO. One write port and
//                one registered read port with read enable; the read
//                register holds its value while i_re is low.
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                i_we/i_waddr/i_wdata - write port
//                i_re/i_raddr    - read request and address
//                o_rdata         - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int c_DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Single-clock FIFO with parametrised width/depth,
//                programmable watermarks, occupancy output, optional
//                first-word-fall-through read mode and sticky error flags.
//  Ports       : clk, rst            - clock / sync active-high reset
//                i_flush             - synchronous flush
//                i_clr_err           - clears o_overrun / o_underrun
//                i_wen, i_wdata      - write request / data
//                i_ren, o_rdata      - read request / data
//                i_upae, i_upaf      - almost-empty / almost-full thresholds
//                o_level             - words held
//                o_empty/o_epo/o_ewm/o_underrun - empty side flags
//                o_full/o_fmo/o_fwm/o_overrun   - full side flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic [ADDR_WIDTH-1:0] i_upae,
  input  logic [ADDR_WIDTH-1:0] i_upaf,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_empty,
  output logic                  o_epo,
  output logic                  o_ewm,
  output logic                  o_underrun,
  output logic                  o_full,
  output logic                  o_fmo,
  output logic                  o_fwm,
  output logic                  o_overrun
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [c_FLAG_W-1:0] c_FLAGS_RST =
    (c_FLAG_W'(1) << c_FLAG_EMPTY) | (c_FLAG_W'(1) << c_FLAG_EWM);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic [c_FLAG_W-1:0]   r_flags;
  logic [c_FLAG_W-1:0]   w_flags_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ram_re;
  logic                  w_empty_nxt;

  // Acceptance uses the registered flags only, so a full FIFO rejects a
  // write even when a read frees a slot in the same cycle.
  assign w_wr_acc    = i_wen && !r_flags[c_FLAG_FULL];
  assign w_rd_acc    = i_ren && !r_flags[c_FLAG_EMPTY];
  assign w_level_nxt = r_level + (ADDR_WIDTH+1)'(w_wr_acc) - (ADDR_WIDTH+1)'(w_rd_acc);

  always_comb begin
    w_flags_nxt                  = '0;
    w_flags_nxt[c_FLAG_FULL]     = (w_level_nxt == c_DEPTH);
    w_flags_nxt[c_FLAG_FMO]      = (w_level_nxt == (c_DEPTH - c_ONE));
    w_flags_nxt[c_FLAG_FWM]      = (w_level_nxt >= (c_DEPTH - {1'b0, i_upaf}));
    w_flags_nxt[c_FLAG_EMPTY]    = w_empty_nxt;
    w_flags_nxt[c_FLAG_EPO]      = (w_level_nxt == c_ONE);
    w_flags_nxt[c_FLAG_EWM]      = (w_level_nxt <= {1'b0, i_upae});
    // Sticky errors; a clear in the same cycle as a new error wins.
    if (!i_clr_err) begin
      w_flags_nxt[c_FLAG_OVERRUN]  = r_flags[c_FLAG_OVERRUN]  || (i_wen && r_flags[c_FLAG_FULL]);
      w_flags_nxt[c_FLAG_UNDERRUN] = r_flags[c_FLAG_UNDERRUN] || (i_ren && r_flags[c_FLAG_EMPTY]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_flags <= c_FLAGS_RST;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      // The read pointer tracks words fetched out of the RAM.
      if (w_ram_re) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (i_wdata),
    .i_re    (w_ram_re),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  generate
    if (FWFT == c_FWFT_ON) begin : g_fwft
      // Two-stage prefetch: RAM read register (stage) then output register.
      // EMPTY doubles as "output register invalid"; LEVEL counts every word
      // still owed to the reader, including those in the pipeline.
      logic                r_svalid;
      logic                w_ovalid;
      logic                w_move;
      logic                w_fetch;
      logic [ADDR_WIDTH:0] w_held;

      assign w_ovalid    = !r_flags[c_FLAG_EMPTY];
      assign w_move      = r_svalid && (!w_ovalid || w_rd_acc);
      assign w_held      = (ADDR_WIDTH+1)'(w_ovalid) + (ADDR_WIDTH+1)'(r_svalid);
      // Fetch only words already in RAM and only if the stage frees up.
      assign w_fetch     = (r_level != w_held) && (!r_svalid || w_move);
      assign w_ram_re    = w_fetch;
      assign w_empty_nxt = !(w_move || (w_ovalid && !w_rd_acc));

      always_ff @(posedge clk) begin
        if (rst || i_flush) begin
          r_svalid <= 1'b0;
          r_rdata  <= '0;
        end else begin
          if (w_fetch) begin
            r_svalid <= 1'b1;
          end else if (w_move) begin
            r_svalid <= 1'b0;
          end
          if (w_move) begin
            r_rdata <= w_ram_rdata;
          end
        end
      end
    end else begin : g_std
      // RAM read register followed by the output register.
      logic r_rd_d;

      assign w_ram_re    = w_rd_acc;
      assign w_empty_nxt = (w_level_nxt == '0);

      always_ff @(posedge clk) begin
        if (rst || i_flush) begin
          r_rd_d  <= 1'b0;
          r_rdata <= '0;
        end else begin
          r_rd_d <= w_rd_acc;
          if (r_rd_d) begin
            r_rdata <= w_ram_rdata;
          end
        end
      end
    end
  endgenerate

  assign o_rdata    = r_rdata;
  assign o_level    = r_level;
  assign o_empty    = r_flags[c_FLAG_EMPTY];
  assign o_epo      = r_flags[c_FLAG_EPO];
  assign o_ewm      = r_flags[c_FLAG_EWM];
  assign o_underrun = r_flags[c_FLAG_UNDERRUN];
  assign o_full     = r_flags[c_FLAG_FULL];
  assign o_fmo      = r_flags[c_FLAG_FMO];
  assign o_fwm      = r_flags[c_FLAG_FWM];
  assign o_overrun  = r_flags[c_FLAG_OVERRUN];

endmodule
`default_nettype wire
